// File: rtl/hdmi_i2c_write_master_pkg.sv
// hdmi_i2c_pkg: shared types and constants for the HDMI I2C write engine.
//   - state_t     : transaction state encoding
//   - DATA_W      : width of one {device, register, data} write word
//   - NUM_BYTES   : bytes per transaction; LAST_BYTE / LAST_BIT : counter end values
//   - Q0..Q3      : quarter-period indices within one SCL period
//   - calc_qdiv() : system clocks per SCL quarter-period
package hdmi_i2c_pkg;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    START   = 3'd1,
    BIT     = 3'd2,
    ACKSLOT = 3'd3,
    STOP    = 3'd4,
    DONE    = 3'd5
  } state_t;

  localparam int unsigned DATA_W    = 24;
  localparam int unsigned NUM_BYTES = 3;
  localparam logic [1:0]  LAST_BYTE = 2'd2;
  localparam logic [2:0]  LAST_BIT  = 3'd7;

  localparam logic [1:0] Q0 = 2'd0;
  localparam logic [1:0] Q1 = 2'd1;
  localparam logic [1:0] Q2 = 2'd2;
  localparam logic [1:0] Q3 = 2'd3;

  function automatic int unsigned calc_qdiv(input int unsigned clk_ref,
                                            input int unsigned i2c_clk);
    return clk_ref / (32'd4 * i2c_clk);
  endfunction

endpackage

// File: rtl/hdmi_i2c_write_master_if.sv
// hdmi_i2c_write_master_if: request/status handshake between the HDMI
// configuration sequencer (master) and the I2C write engine (slave).
//   I2C_DATA : {device address + W, register, data}, MSB first on the bus
//   enable   : level request from the sequencer
//   ACK      : 1 = a NACK was seen in the last transaction
//   END      : 1 = transaction finished, held while enable stays high
interface hdmi_i2c_write_master_if;
  import hdmi_i2c_pkg::*;

  logic [DATA_W-1:0] I2C_DATA;
  logic              enable;
  logic              ACK;
  logic              END;

  modport master (output I2C_DATA, output enable, input ACK, input END);
  modport slave  (input I2C_DATA, input enable, output ACK, output END);

endinterface

// File: rtl/hdmi_i2c_write_master_quarter_tick.sv
// i2c_quarter_tick: divides the system clock down to the I2C quarter-period rate.
//   clk   : system clock
//   reset : asynchronous active-low reset
//   run   : counter runs while high, held at zero while low
//   qtick : one-clk pulse on the last count of each quarter period
module i2c_quarter_tick #(
  parameter int unsigned QDIV = 4
) (
  input  logic clk,
  input  logic reset,
  input  logic run,
  output logic qtick
);

  localparam int unsigned CNT_W = (QDIV < 2) ? 1 : $clog2(QDIV);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(QDIV - 1);

  if (QDIV < 2) begin : g_bad_qdiv
    $error("i2c_quarter_tick: QDIV must be at least 2");
  end

  logic [CNT_W-1:0] r_cnt;

  // Quarter counter: wraps at QDIV-1, parked at zero when not running so the
  // first tick lands a full quarter after the engine leaves IDLE.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_cnt <= '0;
    end else if (!run) begin
      r_cnt <= '0;
    end else if (r_cnt == CNT_LAST) begin
      r_cnt <= '0;
    end else begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

  assign qtick = run && (r_cnt == CNT_LAST);

endmodule

// File: rtl/hdmi_i2c_write_master.sv
// hdmi_i2c_write_master: byte-level I2C write engine for HDMI transmitter setup.
// Sends START, three bytes each followed by an ACK slot, then STOP. A NACK on
// any byte skips the remaining bytes and goes straight to STOP.
//   clk     : system clock, all logic on posedge
//   reset   : asynchronous active-low reset; releases the bus immediately
//   seq     : sequencer handshake (I2C_DATA, enable, ACK, END), slave side
//   I2C_SCL : push-pull SCL, idle high
//   I2C_SDA : open-drain SDA (drives 0 or Z), read back for ACK
module hdmi_i2c_write_master
  import hdmi_i2c_pkg::*;
#(
  parameter int unsigned CLK_ref = 50000000,
  parameter int unsigned I2C_clk = 100000
) (
  input  logic                          clk,
  input  logic                          reset,
  hdmi_i2c_write_master_if.slave        seq,
  output logic                          I2C_SCL,
  inout  wire                           I2C_SDA
);

  localparam int unsigned QDIV = calc_qdiv(CLK_ref, I2C_clk);

  state_t            r_state;
  logic [1:0]        r_q;
  logic [2:0]        r_bit;
  logic [1:0]        r_byte;
  logic [DATA_W-1:0] r_shift;
  logic              r_scl;
  logic              r_sda_low;
  logic              r_ack;
  logic              r_end;

  state_t            w_state_nxt;
  logic [1:0]        w_q_nxt;
  logic [2:0]        w_bit_nxt;
  logic [1:0]        w_byte_nxt;
  logic [DATA_W-1:0] w_shift_nxt;
  logic              w_scl_nxt;
  logic              w_sda_low_nxt;
  logic              w_ack_nxt;
  logic              w_end_nxt;

  logic              w_run;
  logic              w_qtick;
  logic              w_sda_in;

  assign w_run    = (r_state != IDLE) && (r_state != DONE);
  assign w_sda_in = I2C_SDA;

  i2c_quarter_tick #(.QDIV(QDIV)) u_qtick (
    .clk   (clk),
    .reset (reset),
    .run   (w_run),
    .qtick (w_qtick)
  );

  // State and bus-driver registers; reset parks the bus released and idle.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state   <= IDLE;
      r_q       <= Q0;
      r_bit     <= 3'd0;
      r_byte    <= 2'd0;
      r_shift   <= 24'h000000;
      r_scl     <= 1'b1;
      r_sda_low <= 1'b0;
      r_ack     <= 1'b0;
      r_end     <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_q       <= w_q_nxt;
      r_bit     <= w_bit_nxt;
      r_byte    <= w_byte_nxt;
      r_shift   <= w_shift_nxt;
      r_scl     <= w_scl_nxt;
      r_sda_low <= w_sda_low_nxt;
      r_ack     <= w_ack_nxt;
      r_end     <= w_end_nxt;
    end
  end

  // Next-state logic: one bus action per quarter tick, sequenced by r_q.
  always_comb begin
    w_state_nxt   = r_state;
    w_q_nxt       = r_q;
    w_bit_nxt     = r_bit;
    w_byte_nxt    = r_byte;
    w_shift_nxt   = r_shift;
    w_scl_nxt     = r_scl;
    w_sda_low_nxt = r_sda_low;
    w_ack_nxt     = r_ack;
    w_end_nxt     = r_end;

    case (r_state)
      IDLE: begin
        w_scl_nxt     = 1'b1;
        w_sda_low_nxt = 1'b0;
        if (seq.enable) begin
          // Word is captured here; later I2C_DATA changes are ignored.
          w_state_nxt = START;
          w_shift_nxt = seq.I2C_DATA;
          w_ack_nxt   = 1'b0;
          w_end_nxt   = 1'b0;
          w_q_nxt     = Q0;
          w_bit_nxt   = 3'd0;
          w_byte_nxt  = 2'd0;
        end else begin
          w_end_nxt = 1'b0;
        end
      end

      START: begin
        if (w_qtick) begin
          if (r_q == Q0) begin
            w_sda_low_nxt = 1'b1;
            w_q_nxt       = Q1;
          end else begin
            w_scl_nxt   = 1'b0;
            w_state_nxt = BIT;
            w_q_nxt     = Q0;
          end
        end else begin
          w_q_nxt = r_q;
        end
      end

      BIT: begin
        if (w_qtick) begin
          case (r_q)
            Q0: begin
              // Open drain: a 1 bit is sent by releasing the line.
              w_sda_low_nxt = ~r_shift[DATA_W-1];
              w_q_nxt       = Q1;
            end
            Q1: begin
              w_scl_nxt = 1'b1;
              w_q_nxt   = Q2;
            end
            Q2: begin
              w_q_nxt = Q3;
            end
            Q3: begin
              w_scl_nxt   = 1'b0;
              w_shift_nxt = {r_shift[DATA_W-2:0], 1'b0};
              w_q_nxt     = Q0;
              if (r_bit == LAST_BIT) begin
                w_state_nxt = ACKSLOT;
                w_bit_nxt   = 3'd0;
              end else begin
                w_bit_nxt = r_bit + 3'd1;
              end
            end
            default: begin
              w_q_nxt = Q0;
            end
          endcase
        end else begin
          w_q_nxt = r_q;
        end
      end

      ACKSLOT: begin
        if (w_qtick) begin
          case (r_q)
            Q0: begin
              w_sda_low_nxt = 1'b0;
              w_q_nxt       = Q1;
            end
            Q1: begin
              w_scl_nxt = 1'b1;
              w_q_nxt   = Q2;
            end
            Q2: begin
              // Line still high mid-pulse means the slave did not acknowledge.
              if (w_sda_in) begin
                w_ack_nxt = 1'b1;
              end else begin
                w_ack_nxt = r_ack;
              end
              w_q_nxt = Q3;
            end
            Q3: begin
              w_scl_nxt = 1'b0;
              w_q_nxt   = Q0;
              if (r_ack || (r_byte == LAST_BYTE)) begin
                w_state_nxt = STOP;
              end else begin
                w_state_nxt = BIT;
                w_byte_nxt  = r_byte + 2'd1;
                w_bit_nxt   = 3'd0;
              end
            end
            default: begin
              w_q_nxt = Q0;
            end
          endcase
        end else begin
          w_q_nxt = r_q;
        end
      end

      STOP: begin
        if (w_qtick) begin
          case (r_q)
            Q0: begin
              w_sda_low_nxt = 1'b1;
              w_q_nxt       = Q1;
            end
            Q1: begin
              w_scl_nxt = 1'b1;
              w_q_nxt   = Q2;
            end
            Q2: begin
              w_sda_low_nxt = 1'b0;
              w_state_nxt   = DONE;
              w_end_nxt     = 1'b1;
              w_q_nxt       = Q0;
            end
            default: begin
              w_q_nxt = Q0;
            end
          endcase
        end else begin
          w_q_nxt = r_q;
        end
      end

      DONE: begin
        // END and ACK hold until the sequencer drops its request.
        if (!seq.enable) begin
          w_state_nxt = IDLE;
          w_end_nxt   = 1'b0;
        end else begin
          w_end_nxt = 1'b1;
        end
      end

      default: begin
        w_state_nxt   = IDLE;
        w_scl_nxt     = 1'b1;
        w_sda_low_nxt = 1'b0;
        w_end_nxt     = 1'b0;
        w_q_nxt       = Q0;
      end
    endcase
  end

  assign I2C_SCL = r_scl;
  assign I2C_SDA = r_sda_low ? 1'b0 : 1'bz;
  assign seq.ACK = r_ack;
  assign seq.END = r_end;

endmodule

// File: tb/tb_hdmi_i2c_write_master.sv
module tb_hdmi_i2c_write_master;

  typedef struct {
    logic [23:0] bytes;
    int          nbytes;
    logic [2:0]  acks;
    logic        ack;
    int          pulses;
    int          lat;
    int          start_cyc;
  } exp_t;

  logic clk = 1'b0;
  logic reset;
  logic scl_w;
  wire  sda_w;
  logic slave_drv = 1'b0;

  always #5 clk = ~clk;

  hdmi_i2c_write_master_if bus_if ();

  assign sda_w = slave_drv ? 1'b0 : 1'bz;
  pullup (sda_w);

  hdmi_i2c_write_master #(.CLK_ref(1600), .I2C_clk(100)) dut (
    .clk     (clk),
    .reset   (reset),
    .seq     (bus_if.slave),
    .I2C_SCL (scl_w),
    .I2C_SDA (sda_w)
  );

  int   n_checks = 0;
  int   n_fail   = 0;
  int   cyc      = 0;
  exp_t exp_q[$];
  exp_t e;

  // bus monitor state
  logic chk_en = 1'b0;
  logic bit_q[$];
  logic sample;
  int   pulses, starts, stops, width_err, scl_edges, slv_bits;
  int   nack_byte = -1;
  logic seen_rise, seen_fall;
  time  rise_t, fall_t;
  logic end_prev = 1'b0;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] req);
    n_checks++;
    if (got !== req) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, required 0x%0h", name, got, req);
    end
  endtask

  always @(posedge clk) cyc++;

  // START/STOP detection and illegal SDA changes while SCL is high
  always @(sda_w) begin
    if (chk_en && scl_w === 1'b1) begin
      if (sda_w === 1'b0) begin
        starts++;
        pulses = 0; bit_q.delete(); seen_rise = 1'b0; seen_fall = 1'b0;
        width_err = 0; slv_bits = 0;
      end else begin
        stops++;
      end
    end
  end

  always @(posedge scl_w) begin
    if (chk_en) begin
      scl_edges++;
      slv_bits++;
      if (seen_fall && ($time - fall_t) != 80) width_err++;
      rise_t = $time; seen_rise = 1'b1; sample = sda_w;
    end
  end

  always @(negedge scl_w) begin
    if (chk_en) begin
      scl_edges++;
      if (seen_rise) begin
        if (($time - rise_t) != 80) width_err++;
        pulses++;
        bit_q.push_back(sample);
      end
      seen_rise = 1'b0; fall_t = $time; seen_fall = 1'b1;
      // slave: ack after every 8th data bit unless told to NACK that byte
      if ((slv_bits % 9) == 8 && (slv_bits / 9) != nack_byte) slave_drv = 1'b1;
      else slave_drv = 1'b0;
    end else begin
      slave_drv = 1'b0;
    end
  end

  // scoreboard monitor: compare on each END rising
  always @(negedge clk) begin
    logic [23:0] got_bytes;
    logic [2:0]  got_acks;
    int          gn;
    if (bus_if.END === 1'b1 && end_prev === 1'b0) begin
      if (exp_q.size() == 0) begin
        chk("sb_unexpected_end", 32'd1, 32'd0);
      end else begin
        e = exp_q.pop_front();
        got_bytes = 24'h0; got_acks = 3'b000;
        gn = bit_q.size() / 9;
        for (int k = 0; k < gn && k < 3; k++) begin
          for (int b = 0; b < 8; b++) got_bytes[23 - 8*k - b] = bit_q[9*k + b];
          got_acks[k] = bit_q[9*k + 8];
        end
        chk("latency", cyc - e.start_cyc, e.lat);
        chk("scl_pulses", pulses, e.pulses);
        chk("nbytes", gn, e.nbytes);
        chk("bytes", {8'h0, got_bytes}, {8'h0, e.bytes});
        chk("ack_bits", {29'h0, got_acks}, {29'h0, e.acks});
        chk("ACK_out", {31'h0, bus_if.ACK}, {31'h0, e.ack});
        chk("start_cnt", starts, 1);
        chk("stop_cnt", stops, 1);
        chk("scl_width", width_err, 0);
      end
    end
    end_prev = bus_if.END;
  end

  task automatic launch(input logic [23:0] d, input logic [23:0] xb, input int nb,
                        input logic [2:0] xa, input logic xack, input int lat, input bit push);
    exp_t x;
    @(negedge clk);
    bus_if.I2C_DATA = d;
    bus_if.enable   = 1'b1;
    starts = 0; stops = 0;
    x.bytes = xb; x.nbytes = nb; x.acks = xa; x.ack = xack;
    x.pulses = nb * 9; x.lat = lat; x.start_cyc = cyc + 1;
    if (push) exp_q.push_back(x);
  endtask

  task automatic wait_end(input int max);
    int n = 0;
    while (bus_if.END !== 1'b1 && n < max) begin
      @(negedge clk);
      n++;
    end
    chk("wait_end", {31'h0, bus_if.END}, 32'd1);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int e0, drop;
    reset = 1'b0;
    bus_if.enable = 1'b0;
    bus_if.I2C_DATA = 24'h0;
    repeat (3) @(negedge clk);
    chk("rst_scl", {31'h0, scl_w}, 32'd1);
    chk("rst_sda", {31'h0, sda_w}, 32'd1);
    chk("rst_ack", {31'h0, bus_if.ACK}, 32'd0);
    chk("rst_end", {31'h0, bus_if.END}, 32'd0);
    reset = 1'b1;
    chk_en = 1'b1;
    @(negedge clk);

    // full-ack transaction
    launch(24'h729803, 24'h729803, 3, 3'b000, 1'b0, 452, 1'b1);
    wait_end(600);

    // enable held after END: END stays, bus quiet
    e0 = scl_edges; drop = 0;
    repeat (1000) begin
      @(negedge clk);
      if (bus_if.END !== 1'b1) drop++;
    end
    chk("hold_end", drop, 0);
    chk("hold_scl_quiet", scl_edges - e0, 0);
    bus_if.enable = 1'b0;
    @(negedge clk);
    chk("end_drop", {31'h0, bus_if.END}, 32'd0);

    // NACK on register byte
    nack_byte = 1;
    launch(24'h729803, 24'h729800, 2, 3'b010, 1'b1, 308, 1'b1);
    wait_end(600);
    bus_if.enable = 1'b0;
    repeat (5) @(negedge clk);
    chk("ack_hold_idle", {31'h0, bus_if.ACK}, 32'd1);
    chk("end_idle", {31'h0, bus_if.END}, 32'd0);
    nack_byte = -1;

    // one-clk enable pulse, data changed afterwards
    launch(24'h72AF16, 24'h72AF16, 3, 3'b000, 1'b0, 452, 1'b1);
    @(negedge clk);
    bus_if.enable = 1'b0;
    bus_if.I2C_DATA = 24'h5A5A5A;
    wait_end(600);
    @(negedge clk);
    chk("end_one_cycle", {31'h0, bus_if.END}, 32'd0);

    // reset at quarter ~50
    launch(24'h729803, 24'h0, 0, 3'b000, 1'b0, 0, 1'b0);
    repeat (200) @(negedge clk);
    chk_en = 1'b0;
    slave_drv = 1'b0;
    reset = 1'b0;
    #1;
    chk("midrst_scl", {31'h0, scl_w}, 32'd1);
    chk("midrst_sda", {31'h0, sda_w}, 32'd1);
    chk("midrst_ack", {31'h0, bus_if.ACK}, 32'd0);
    chk("midrst_end", {31'h0, bus_if.END}, 32'd0);
    bus_if.enable = 1'b0;
    repeat (3) @(negedge clk);
    reset = 1'b1;
    chk_en = 1'b1;
    @(negedge clk);

    // clean transaction after reset
    launch(24'h1A2B3C, 24'h1A2B3C, 3, 3'b000, 1'b0, 452, 1'b1);
    wait_end(600);
    bus_if.enable = 1'b0;
    repeat (5) @(negedge clk);
    chk("sb_drained", exp_q.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
